// File: rtl/store_buf.sv
// Store buffer between the MEM stage and a single-ported data memory.
// Buffered stores drain in program order whenever the load does not own the port.
// A load to a word with a pending store stalls until that store has drained.
// Optional feature macro: STORE_BUF_FWD_EN enables forwarding of an aligned
// MemW store to a MemW load instead of stalling.
module store_buf #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_type,
  input  logic [31:0] st_pc,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_type,
  output logic        ld_stall,
  output logic        ld_fwd_valid,
  output logic [31:0] ld_fwd_data,
  output logic        dm_WE,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_WD,
  output logic [1:0]  dm_MemType,
  output logic [31:0] dm_PC,
  output logic        empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      e_addr [DEPTH];
  logic [31:0]      e_data [DEPTH];
  logic [1:0]       e_type [DEPTH];
  logic [31:0]      e_pc   [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             hit_any;
  logic             hit;
  logic             load_own;
  logic             push;
  logic             pop;
  logic             fwd;

`ifdef STORE_BUF_FWD_EN
  localparam logic [1:0] MEM_W = 2'b00;
  logic [PTR_W-1:0] young;
`endif

  assign st_ready = count < CNT_W'(DEPTH);
  assign empty    = count == '0;
  assign push     = st_valid && st_ready;

  // Word-address match against every occupied slot; later matches are younger.
  always_comb begin
    hit_any = 1'b0;
`ifdef STORE_BUF_FWD_EN
    young = head;
`endif
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count &&
          e_addr[head + PTR_W'(k)][31:2] == ld_addr[31:2]) begin
        hit_any = 1'b1;
`ifdef STORE_BUF_FWD_EN
        young = head + PTR_W'(k);
`endif
      end
    end
  end

  assign hit      = ld_valid && hit_any;
  assign load_own = ld_valid && !hit;
  assign pop      = !load_own && (count != '0);

`ifdef STORE_BUF_FWD_EN
  assign fwd          = hit && (ld_type == MEM_W) && (e_type[young] == MEM_W) &&
                        (e_addr[young][1:0] == 2'b00);
  assign ld_fwd_data  = fwd ? e_data[young] : 32'h0;
`else
  assign fwd          = 1'b0;
  assign ld_fwd_data  = 32'h0;
`endif
  assign ld_fwd_valid = fwd;
  assign ld_stall     = hit && !fwd;

  // Memory port mux: the head store writes when draining, otherwise the load reads.
  always_comb begin
    dm_WE      = 1'b0;
    dm_addr    = ld_addr;
    dm_MemType = ld_type;
    dm_WD      = 32'h0;
    dm_PC      = 32'h0;
    if (pop) begin
      dm_WE      = 1'b1;
      dm_addr    = e_addr[head];
      dm_WD      = e_data[head];
      dm_MemType = e_type[head];
      dm_PC      = e_pc[head];
    end
  end

  // Pointer and occupancy bookkeeping; reset discards all pending stores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload capture; validity comes from the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      e_addr[tail] <= st_addr;
      e_data[tail] <= st_data;
      e_type[tail] <= st_type;
      e_pc[tail]   <= st_pc;
    end
  end

endmodule

// File: tb/tb_store_buf.sv
// Directed self-checking bench for store_buf (DEPTH = 4).
module tb_store_buf;

  localparam logic [1:0] MEM_W = 2'b00;
  localparam logic [1:0] MEM_B = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_type;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [1:0]  ld_type;
  logic        ld_stall;
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;
  logic        dm_WE;
  logic [31:0] dm_addr;
  logic [31:0] dm_WD;
  logic [1:0]  dm_MemType;
  logic [31:0] dm_PC;
  logic        empty;

  int checks = 0;
  int errors = 0;

  store_buf #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_type(st_type), .st_pc(st_pc),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_type(ld_type),
    .ld_stall(ld_stall), .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
    .dm_WE(dm_WE), .dm_addr(dm_addr), .dm_WD(dm_WD), .dm_MemType(dm_MemType), .dm_PC(dm_PC),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; st_type = MEM_W; st_pc = 32'h0;
    ld_valid = 1'b0; ld_addr = 32'h0; ld_type = MEM_W;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %b exp 1", st_ready); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (ld_stall !== 1'b0) begin errors++; $display("FAIL reset_ld_stall got %b exp 0", ld_stall); end
    checks++; if (ld_fwd_valid !== 1'b0 || ld_fwd_data !== 32'h0) begin errors++; $display("FAIL reset_fwd got %b/%h exp 0/0", ld_fwd_valid, ld_fwd_data); end
    checks++; if (dm_WE !== 1'b0) begin errors++; $display("FAIL reset_dm_we got %b exp 0", dm_WE); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (st_ready !== 1'b1 || empty !== 1'b1 || dm_WE !== 1'b0) begin errors++; $display("FAIL reset_release got rdy=%b empty=%b we=%b exp 1 1 0", st_ready, empty, dm_WE); end
  endtask

  task automatic test_single_store();
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h10; st_data = 32'h1234_5678; st_type = MEM_W; st_pc = 32'h400;
    #1;
    checks++; if (dm_WE !== 1'b0) begin errors++; $display("FAIL single_same_cycle_we got %b exp 0", dm_WE); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (dm_WE !== 1'b1) begin errors++; $display("FAIL single_we got %b exp 1", dm_WE); end
    checks++; if (dm_addr !== 32'h10 || dm_WD !== 32'h1234_5678) begin errors++; $display("FAIL single_payload got %h/%h exp 00000010/12345678", dm_addr, dm_WD); end
    checks++; if (dm_MemType !== MEM_W || dm_PC !== 32'h400) begin errors++; $display("FAIL single_type_pc got %b/%h exp 00/00000400", dm_MemType, dm_PC); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_not_empty got %b exp 0", empty); end
    @(negedge clk);
    #1;
    checks++; if (empty !== 1'b1 || dm_WE !== 1'b0) begin errors++; $display("FAIL single_drained got empty=%b we=%b exp 1 0", empty, dm_WE); end
  endtask

  task automatic test_full();
    logic [31:0] exp_a [5];
    exp_a[0] = 32'h0; exp_a[1] = 32'h4; exp_a[2] = 32'h8; exp_a[3] = 32'hC; exp_a[4] = 32'h20;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 32'h100; ld_type = MEM_W;
      st_valid = 1'b1; st_addr = exp_a[i]; st_data = exp_a[i] + 32'h1000; st_type = MEM_W; st_pc = 32'h0;
      #1;
      checks++; if (st_ready !== 1'b1 || dm_WE !== 1'b0 || dm_addr !== 32'h100) begin errors++; $display("FAIL full_fill%0d got rdy=%b we=%b addr=%h exp 1 0 00000100", i, st_ready, dm_WE, dm_addr); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      st_addr = exp_a[4]; st_data = exp_a[4] + 32'h1000;
      #1;
      checks++; if (st_ready !== 1'b0 || dm_WE !== 1'b0) begin errors++; $display("FAIL full_hold%0d got rdy=%b we=%b exp 0 0", i, st_ready, dm_WE); end
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      ld_valid = 1'b0;
      if (j >= 2) st_valid = 1'b0;
      #1;
      checks++; if (dm_WE !== 1'b1 || dm_addr !== exp_a[j] || dm_WD !== exp_a[j] + 32'h1000) begin errors++; $display("FAIL full_drain%0d got we=%b addr=%h wd=%h exp 1 %h %h", j, dm_WE, dm_addr, dm_WD, exp_a[j], exp_a[j] + 32'h1000); end
      if (j == 0) begin checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass got %b exp 0", st_ready); end end
      if (j == 1) begin checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL full_accept_next got %b exp 1", st_ready); end end
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (empty !== 1'b1 || dm_WE !== 1'b0) begin errors++; $display("FAIL full_end got empty=%b we=%b exp 1 0", empty, dm_WE); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 32'h300; ld_type = MEM_W;
    st_valid = 1'b1; st_addr = 32'h200; st_data = 32'h11; st_type = MEM_W; st_pc = 32'h0;
    @(negedge clk);
    st_addr = 32'h41; st_data = 32'hAB; st_type = MEM_B;
    #1;
    checks++; if (dm_WE !== 1'b0 || ld_stall !== 1'b0) begin errors++; $display("FAIL stall_unrelated got we=%b stall=%b exp 0 0", dm_WE, ld_stall); end
    @(negedge clk);
    st_valid = 1'b0; ld_addr = 32'h40;
    #1;
    checks++; if (ld_stall !== 1'b1 || dm_WE !== 1'b1 || dm_addr !== 32'h200) begin errors++; $display("FAIL stall_first got stall=%b we=%b addr=%h exp 1 1 00000200", ld_stall, dm_WE, dm_addr); end
    @(negedge clk);
    #1;
    checks++; if (ld_stall !== 1'b1 || dm_addr !== 32'h41 || dm_WD !== 32'hAB || dm_MemType !== MEM_B) begin errors++; $display("FAIL stall_second got stall=%b addr=%h wd=%h type=%b exp 1 00000041 000000ab 10", ld_stall, dm_addr, dm_WD, dm_MemType); end
    @(negedge clk);
    #1;
    checks++; if (ld_stall !== 1'b0 || dm_WE !== 1'b0 || dm_addr !== 32'h40 || dm_MemType !== MEM_W) begin errors++; $display("FAIL stall_release got stall=%b we=%b addr=%h type=%b exp 0 0 00000040 00", ld_stall, dm_WE, dm_addr, dm_MemType); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_fwd();
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 32'h80; ld_type = MEM_W;
    st_valid = 1'b1; st_addr = 32'h80; st_data = 32'hDEAD_BEEF; st_type = MEM_W; st_pc = 32'h0;
    #1;
    checks++; if (ld_stall !== 1'b0 || ld_fwd_valid !== 1'b0 || dm_WE !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle got stall=%b fwd=%b we=%b exp 0 0 0", ld_stall, ld_fwd_valid, dm_WE); end
    @(negedge clk);
    st_valid = 1'b0;
    #1;
`ifdef STORE_BUF_FWD_EN
    checks++; if (ld_fwd_valid !== 1'b1 || ld_fwd_data !== 32'hDEAD_BEEF || ld_stall !== 1'b0) begin errors++; $display("FAIL fwd_hit got fwd=%b data=%h stall=%b exp 1 deadbeef 0", ld_fwd_valid, ld_fwd_data, ld_stall); end
`else
    checks++; if (ld_fwd_valid !== 1'b0 || ld_fwd_data !== 32'h0 || ld_stall !== 1'b1) begin errors++; $display("FAIL fwd_hit got fwd=%b data=%h stall=%b exp 0 00000000 1", ld_fwd_valid, ld_fwd_data, ld_stall); end
`endif
    checks++; if (dm_WE !== 1'b1 || dm_addr !== 32'h80) begin errors++; $display("FAIL fwd_drain got we=%b addr=%h exp 1 00000080", dm_WE, dm_addr); end
    @(negedge clk);
    #1;
    checks++; if (empty !== 1'b1 || ld_stall !== 1'b0 || ld_fwd_valid !== 1'b0) begin errors++; $display("FAIL fwd_after got empty=%b stall=%b fwd=%b exp 1 0 0", empty, ld_stall, ld_fwd_valid); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 32'h300; ld_type = MEM_W;
      st_valid = 1'b1; st_addr = 32'h700 + 32'(4 * i); st_data = 32'h55; st_type = MEM_W; st_pc = 32'h0;
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (empty !== 1'b0 || dm_WE !== 1'b1) begin errors++; $display("FAIL rmid_before got empty=%b we=%b exp 0 1", empty, dm_WE); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || st_ready !== 1'b1 || dm_WE !== 1'b0 || ld_stall !== 1'b0) begin errors++; $display("FAIL rmid_cleared got empty=%b rdy=%b we=%b stall=%b exp 1 1 0 0", empty, st_ready, dm_WE, ld_stall); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (dm_WE !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL rmid_after%0d got we=%b empty=%b exp 0 1", i, dm_WE, empty); end
    end
  endtask

  task automatic test_back_to_back();
    int pushed;
    int writes;
    int mcount;
    logic ldv;
    logic exp_we;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    pushed = 0; writes = 0; mcount = 0;
    for (int cyc = 0; cyc < 60 && writes < 10; cyc++) begin
      @(negedge clk);
      ldv = (cyc < 6);
      ld_valid = ldv; ld_addr = 32'h300; ld_type = MEM_W;
      st_valid = (pushed < 10);
      st_addr = 32'h600 + 32'(4 * pushed); st_data = 32'hA000 + 32'(pushed);
      st_type = MEM_W; st_pc = 32'h1000 + 32'(4 * pushed);
      #1;
      exp_we = !ldv && (mcount > 0);
      checks++; if (st_ready !== (mcount < 4)) begin errors++; $display("FAIL b2b_ready c%0d got %b exp %b", cyc, st_ready, (mcount < 4)); end
      checks++; if (dm_WE !== exp_we) begin errors++; $display("FAIL b2b_we c%0d got %b exp %b", cyc, dm_WE, exp_we); end
      if (exp_we) begin
        checks++; if (dm_addr !== q_addr[0] || dm_WD !== q_data[0]) begin errors++; $display("FAIL b2b_order c%0d got %h/%h exp %h/%h", cyc, dm_addr, dm_WD, q_addr[0], q_data[0]); end
        void'(q_addr.pop_front()); void'(q_data.pop_front());
        writes++;
      end
      if (st_valid && mcount < 4) begin
        q_addr.push_back(st_addr); q_data.push_back(st_data);
        pushed++;
      end
      mcount = mcount + ((st_valid && mcount < 4) ? 1 : 0) - (exp_we ? 1 : 0);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (writes !== 10 || empty !== 1'b1) begin errors++; $display("FAIL b2b_total got writes=%0d empty=%b exp 10 1", writes, empty); end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_full();
    test_stall();
    test_fwd();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
